// File: rtl/adder_pipe_arbiter.sv
// -----------------------------------------------------------------------------
// adder_pipe_arbiter
//
// Purpose:
//   Shares one WIDTH-stage pipelined adder (external n_bit_adder with a global
//   enable) among NREQ requesters. Each cycle at most one requester is granted
//   and its operands are driven into the adder. A tag pipeline of WIDTH
//   {valid, id} entries travels alongside the adder stages so every sum leaves
//   with the ID of the requester that issued it. Response backpressure freezes
//   the adder and the tag pipeline together through add_en.
//
// Configuration:
//   ADDER_ARB_RR_EN  defined   -> round-robin arbitration (pointer register).
//                    undefined -> fixed priority, lowest index wins.
//
// Ports:
//   clk        in   clock, shared with the adder
//   rst        in   synchronous active-low reset
//   req_valid  in   [NREQ]        per-requester operand valid
//   req_a/b    in   [NREQ*WIDTH]  packed operands, requester k at [k*WIDTH +: WIDTH]
//   req_cin    in   [NREQ]        per-requester carry-in
//   req_ready  out  [NREQ]        one-hot grant (transfer on valid & ready)
//   add_a/b    out  [WIDTH]       adder operands (zero when nothing issues)
//   add_cin    out                adder carry-in
//   add_en     out                adder stage enable (low = stall)
//   add_s      in   [WIDTH]       adder sum
//   add_c      in                 adder carry-out
//   rsp_valid  out                result valid at the pipeline head
//   rsp_ready  in                 consumer accepts the result
//   rsp_id     out  [IDW]         requester that issued the head result
//   rsp_s      out  [WIDTH]       sum (pass-through of add_s)
//   rsp_c      out                carry (pass-through of add_c)
//   inflight   out  [clog2(WIDTH+1)] number of valid tags in the pipeline
// -----------------------------------------------------------------------------
module adder_pipe_arbiter #(
    parameter int WIDTH = 8,                // operand width and pipeline depth (>= 2)
    parameter int NREQ  = 4,                // number of requesters (>= 2)
    parameter int IDW   = $clog2(NREQ)      // requester-ID width
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*WIDTH-1:0]       req_a,
    input  logic [NREQ*WIDTH-1:0]       req_b,
    input  logic [NREQ-1:0]             req_cin,
    output logic [NREQ-1:0]             req_ready,
    output logic [WIDTH-1:0]            add_a,
    output logic [WIDTH-1:0]            add_b,
    output logic                        add_cin,
    output logic                        add_en,
    input  logic [WIDTH-1:0]            add_s,
    input  logic                        add_c,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IDW-1:0]              rsp_id,
    output logic [WIDTH-1:0]            rsp_s,
    output logic                        rsp_c,
    output logic [$clog2(WIDTH+1)-1:0]  inflight
);

    localparam int CNTW = $clog2(WIDTH + 1);

    // Tag pipeline: entry 0 loads on every enabled edge, entry WIDTH-1 is the head.
    logic [WIDTH-1:0]  r_tag_valid;
    logic [IDW-1:0]    r_tag_id [WIDTH];
    logic [CNTW-1:0]   r_inflight;

    logic              w_rsp_valid;
    logic              w_add_en;
    logic              w_issue;
    logic              w_retire;
    logic [NREQ-1:0]   w_grant;
    logic [IDW-1:0]    w_grant_id;
    logic [IDW-1:0]    w_search_base;

`ifdef ADDER_ARB_RR_EN
    // Round-robin pointer: first index searched on the next grant.
    logic [IDW-1:0]    r_rr_ptr;
    assign w_search_base = r_rr_ptr;
`else
    // Fixed priority is the same search anchored at index 0.
    assign w_search_base = '0;
`endif

    // Gating with rst keeps stale head tags invisible while reset is held,
    // which in turn forces add_en high and all grants low during reset.
    assign w_rsp_valid = rst & r_tag_valid[WIDTH-1];
    assign w_add_en    = !(w_rsp_valid && !rsp_ready);
    assign w_retire    = w_rsp_valid & rsp_ready;
    assign w_issue     = |w_grant;

    // -------------------------------------------------------------------------
    // Arbitration: scan NREQ slots starting at the search base, wrapping modulo
    // NREQ, and grant the first valid requester. Nothing is granted while the
    // pipeline is stalled, because the adder cannot accept a new operand set.
    // -------------------------------------------------------------------------
    always_comb begin : arbitrate
        logic [IDW-1:0] idx;
        logic           found;
        // NOTE: every variable gets a default before any conditional write, so
        // no path leaves it unassigned and no latch is inferred; blocking '='
        // is correct here because later loop iterations must see 'found'.
        w_grant    = '0;
        w_grant_id = '0;
        idx        = '0;
        found      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(w_search_base) + i) % NREQ);
            if (!found && rst && w_add_en && req_valid[idx]) begin
                found        = 1'b1;
                w_grant[idx] = 1'b1;
                w_grant_id   = idx;
            end
        end
    end

    // Operand steering: the grant is one-hot, so a plain select suffices.
    // With no grant the adder sees zeros (a bubble).
    always_comb begin : steer
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant[k]) begin
                add_a   = req_a[k*WIDTH +: WIDTH];
                add_b   = req_b[k*WIDTH +: WIDTH];
                add_cin = req_cin[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Tag valid bits and in-flight counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every register samples
        // pre-edge values, independent of block ordering.
        if (!rst) begin
            r_tag_valid <= '0;
            r_inflight  <= '0;
        end else begin
            if (w_add_en) begin
                r_tag_valid <= {r_tag_valid[WIDTH-2:0], w_issue};
            end
            // Issue and retire in the same cycle cancel out.
            case ({w_issue, w_retire})
                2'b10:   r_inflight <= r_inflight + CNTW'(1);
                2'b01:   r_inflight <= r_inflight - CNTW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // NOTE: the ID array is deliberately not reset; each ID is only observed
    // alongside its valid bit, which is reset, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (w_add_en) begin
            r_tag_id[0] <= w_grant_id;      // zero on a bubble
            for (int i = 1; i < WIDTH; i++) begin
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

`ifdef ADDER_ARB_RR_EN
    // Pointer moves to the slot after the winner, and only on a grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr <= '0;
        end else if (w_issue) begin
            r_rr_ptr <= (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + IDW'(1);
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign req_ready = w_grant;
    assign add_en    = w_add_en;
    assign rsp_valid = w_rsp_valid;
    assign rsp_id    = r_tag_id[WIDTH-1];
    assign rsp_s     = add_s;
    assign rsp_c     = add_c;
    assign inflight  = r_inflight;

endmodule

// File: tb/tb_adder_pipe_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe_arbiter
//
// Directed bench for adder_pipe_arbiter (WIDTH=8, NREQ=4). A behavioural
// 8-stage adder with a global enable stands in for n_bit_adder. Each scenario
// is a per-cycle table of requester valids, consumer ready, expected grant,
// expected rsp_valid and selected expected inflight values; expected results
// come from a hand-computed sum table, queued in expected grant order.
// Grant expectations follow ADDER_ARB_RR_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_adder_pipe_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int CNTW  = 4;
    localparam int MAXC  = 32;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*WIDTH-1:0]  req_a;
    logic [NREQ*WIDTH-1:0]  req_b;
    logic [NREQ-1:0]        req_cin;
    logic [NREQ-1:0]        req_ready;
    logic [WIDTH-1:0]       add_a;
    logic [WIDTH-1:0]       add_b;
    logic                   add_cin;
    logic                   add_en;
    logic [WIDTH-1:0]       add_s;
    logic                   add_c;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH-1:0]       rsp_s;
    logic                   rsp_c;
    logic [CNTW-1:0]        inflight;

    adder_pipe_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_ready (req_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_en    (add_en),
        .add_s     (add_s),
        .add_c     (add_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_c     (rsp_c),
        .inflight  (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the shared adder: WIDTH stages, global enable,
    // no reset (stale contents survive a reset of the arbiter).
    logic [WIDTH:0] m_pipe [WIDTH];
    always @(posedge clk) begin
        if (add_en) begin
            m_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
            for (int i = 1; i < WIDTH; i++) m_pipe[i] <= m_pipe[i-1];
        end
    end
    assign add_s = m_pipe[WIDTH-1][WIDTH-1:0];
    assign add_c = m_pipe[WIDTH-1][WIDTH];

    // Operand table and hand-computed {carry, sum}.
    //   r0: 0x10 + 0x01 + 0 = 0x011
    //   r1: 0xFF + 0xFF + 1 = 0x1FF  (overflow: s=0xFF, c=1)
    //   r2: 0x7F + 0x01 + 1 = 0x081
    //   r3: 0xFE + 0x01 + 0 = 0x0FF
    logic [WIDTH-1:0] op_a    [NREQ] = '{8'h10, 8'hFF, 8'h7F, 8'hFE};
    logic [WIDTH-1:0] op_b    [NREQ] = '{8'h01, 8'hFF, 8'h01, 8'h01};
    logic             op_cin  [NREQ] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [WIDTH:0]   exp_sum [NREQ] = '{9'h011, 9'h1FF, 9'h081, 9'h0FF};

    // Per-cycle scenario tables.
    logic [NREQ-1:0] sv_mask  [MAXC];
    logic [NREQ-1:0] sv_grant [MAXC];
    logic            sv_rdy   [MAXC];
    logic            sv_rv    [MAXC];
    int              sv_infl  [MAXC];
    int              sv_len;
    string           scen;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [WIDTH:0] sum;
    } rsp_t;
    rsp_t sb [$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int onehot_id(input logic [NREQ-1:0] g);
        int r = 0;
        for (int k = 0; k < NREQ; k++) if (g[k]) r = k;
        return r;
    endfunction

    task automatic clear_sv(input string name, input int len);
        scen   = name;
        sv_len = len;
        sb.delete();
        for (int n = 0; n < MAXC; n++) begin
            sv_mask[n]  = '0;
            sv_grant[n] = '0;
            sv_rdy[n]   = 1'b1;
            sv_rv[n]    = 1'b0;
            sv_infl[n]  = -1;
        end
    endtask

    // Synchronous reset held for two edges, with requests and backpressure
    // applied to show they are ignored while reset is active.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req_valid = '1; rsp_ready = 1'b0;
        #1;
        check("rst/req_ready", req_ready, 0);
        check("rst/add_en", add_en, 1);
        check("rst/rsp_valid", rsp_valid, 0);
        @(negedge clk);
        #1;
        check("rst/inflight", inflight, 0);
        check("rst/rsp_valid2", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    endtask

    task automatic run_sv();
        int id;
        for (int n = 0; n < sv_len; n++) begin
            @(negedge clk);
            req_valid = sv_mask[n];
            rsp_ready = sv_rdy[n];
            #1;
            check($sformatf("%s/c%0d/req_ready", scen, n), req_ready, sv_grant[n]);
            check($sformatf("%s/c%0d/add_en", scen, n), add_en, !(sv_rv[n] && !sv_rdy[n]));
            check($sformatf("%s/c%0d/rsp_valid", scen, n), rsp_valid, sv_rv[n]);
            if (sv_grant[n] != '0) begin
                id = onehot_id(sv_grant[n]);
                check($sformatf("%s/c%0d/add_ops", scen, n),
                      {add_cin, add_a, add_b}, {op_cin[id], op_a[id], op_b[id]});
                sb.push_back('{id: IDW'(id), sum: exp_sum[id]});
            end else begin
                check($sformatf("%s/c%0d/add_bubble", scen, n), {add_cin, add_a, add_b}, 0);
            end
            if (sv_infl[n] >= 0)
                check($sformatf("%s/c%0d/inflight", scen, n), inflight, sv_infl[n]);
            if (sv_rv[n] && sb.size() > 0) begin
                check($sformatf("%s/c%0d/rsp_id", scen, n), rsp_id, sb[0].id);
                check($sformatf("%s/c%0d/rsp_sum", scen, n), {rsp_c, rsp_s}, sb[0].sum);
                if (sv_rdy[n]) void'(sb.pop_front());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            req_a[k*WIDTH +: WIDTH] = op_a[k];
            req_b[k*WIDTH +: WIDTH] = op_b[k];
            req_cin[k]              = op_cin[k];
        end

        // Single request from requester 2 (0x7F+0x01+1), then overflow from 1.
        do_reset();
        clear_sv("single", 11);
        sv_mask[0] = 4'b0100; sv_grant[0] = 4'b0100;
        sv_mask[1] = 4'b0010; sv_grant[1] = 4'b0010;
        sv_rv[8] = 1'b1; sv_rv[9] = 1'b1;
        sv_infl[1] = 1; sv_infl[2] = 2; sv_infl[8] = 2; sv_infl[9] = 1; sv_infl[10] = 0;
        run_sv();

        // Back-to-back: all requesters valid for 8 cycles.
        do_reset();
        clear_sv("b2b", 17);
        for (int n = 0; n < 8; n++) begin
            sv_mask[n] = 4'b1111;
`ifdef ADDER_ARB_RR_EN
            sv_grant[n] = 4'(1 << (n % 4));
`else
            sv_grant[n] = 4'b0001;
`endif
            sv_rv[n+8] = 1'b1;
        end
        sv_infl[4] = 4; sv_infl[8] = 8; sv_infl[12] = 4; sv_infl[16] = 0;
        run_sv();

        // Requesters 1 and 3 continuously valid for 10 cycles.
        do_reset();
        clear_sv("pair", 21);
        for (int n = 0; n < 10; n++) begin
            sv_mask[n] = 4'b1010;
`ifdef ADDER_ARB_RR_EN
            sv_grant[n] = (n % 2 == 0) ? 4'b0010 : 4'b1000;
`else
            sv_grant[n] = 4'b0010;
`endif
            sv_rv[n+8] = 1'b1;
        end
        sv_infl[8] = 8; sv_infl[9] = 8; sv_infl[10] = 8; sv_infl[20] = 0;
        run_sv();

        // Backpressure: 4 results, consumer stalls 5 cycles on the first one
        // while all requesters are asserting valid.
        do_reset();
        clear_sv("bp", 18);
        for (int n = 0; n < 4; n++) begin
            sv_mask[n] = 4'b1111;
`ifdef ADDER_ARB_RR_EN
            sv_grant[n] = 4'(1 << n);
`else
            sv_grant[n] = 4'b0001;
`endif
        end
        for (int n = 8; n < 13; n++) begin
            sv_mask[n] = 4'b1111;
            sv_rdy[n]  = 1'b0;
            sv_infl[n] = 4;
        end
        for (int n = 8; n < 17; n++) sv_rv[n] = 1'b1;
        sv_infl[4] = 4; sv_infl[13] = 4; sv_infl[14] = 3; sv_infl[17] = 0;
        run_sv();

        // Mid-flight reset: 5 results in flight, then one reset edge.
        do_reset();
        clear_sv("midrst", 6);
        for (int n = 0; n < 5; n++) begin
            sv_mask[n] = 4'b1111;
`ifdef ADDER_ARB_RR_EN
            sv_grant[n] = 4'(1 << (n % 4));
`else
            sv_grant[n] = 4'b0001;
`endif
        end
        sv_infl[5] = 5;
        run_sv();
        @(negedge clk);
        rst = 1'b0; req_valid = '1; rsp_ready = 1'b0;
        #1;
        check("midrst/hold_inflight", inflight, 5);
        check("midrst/rst_ready", req_ready, 0);
        check("midrst/rst_add_en", add_en, 1);
        @(negedge clk);
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        #1;
        check("midrst/inflight0", inflight, 0);
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("midrst/no_stale%0d", i), rsp_valid, 0);
        end
        // Arbitration pointer (if any) is back at 0 after reset.
        @(negedge clk);
        req_valid = '1;
        #1;
        check("midrst/ptr_reset", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_pipe_arbiter.md
# adder_pipe_arbiter

Shares one `n_bit_adder` (WIDTH-stage pipelined ripple-carry adder with a global `en` stall) among NREQ requesters. Each cycle it grants at most one requester and drives that operand set into the adder. A tag pipeline mirrors the adder stages, so every sum leaves with its requester ID. Response backpressure stalls the whole adder through `en`. Sits between the requester fabric and the adder instance; the adder's `s`/`c` outputs connect straight to this block.

## Interface
- `WIDTH`, 8, operand width; also the adder pipeline depth in stages.
- `NREQ`, 4, number of requesters, ≥2.
- `IDW`, $clog2(NREQ), requester-ID width.
- `clk`  in  1  clock, shared with the adder.
- `rst`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_a`, `req_b`  in  NREQ*WIDTH  packed operands; requester k uses bits [k*WIDTH +: WIDTH].
- `req_cin`  in  NREQ  carry-in per requester.
- `req_ready`  out  NREQ  one-hot grant; a transfer occurs on `req_valid[k] & req_ready[k]`.
- `add_a`, `add_b`  out  WIDTH  to adder `a`, `b`.
- `add_cin`  out  1  to adder `cin`.
- `add_en`  out  1  to adder `en`.
- `add_s`  in  WIDTH  from adder `s`.
- `add_c`  in  1  from adder `c`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  IDW  requester that issued the result.
- `rsp_s`  out  WIDTH  sum, equal to `add_s`.
- `rsp_c`  out  1  carry-out, equal to `add_c`.
- `inflight`  out  $clog2(WIDTH+1)  count of valid tags in the pipeline.

## Operation
- Tag pipeline: WIDTH entries of {valid, id}. Entry 0 loads on an issue; entry WIDTH-1 drives `rsp_valid` / `rsp_id`. It shifts only when `add_en`=1.
- Stall: `add_en = !(rsp_valid && !rsp_ready)`. Adder and tag pipeline freeze together.
- Grant:
  - `req_ready[k]`=1 only when `add_en`=1, `req_valid[k]`=1, and k wins arbitration. Otherwise all `req_ready` bits are 0.
  - `req_ready` is combinational from `req_valid`, the arbitration state and `add_en`.
- Issue:
  - On a grant, `add_a`/`add_b`/`add_cin` carry the winner's operands and tag entry 0 loads {1, k}.
  - With no grant, the adder inputs are driven to 0 and entry 0 loads {0, 0} as a bubble.
- Response: `rsp_s`/`rsp_c` pass through from `add_s`/`add_c`. The result retires on `rsp_valid & rsp_ready`.
- `inflight`: +1 on an issue, −1 on a retire, unchanged when both or neither happen. Maximum value is WIDTH.
- Arithmetic: `{rsp_c, rsp_s}` = `a + b + cin` for the issuing requester, modulo 2^(WIDTH+1).
- Reset (`rst`=0 at a clk edge):
  - All tag valid bits clear, `inflight` = 0, arbitration pointer = 0.
  - Outputs during reset: `rsp_valid`=0, `req_ready`=0, `add_en`=1. Stale adder contents are never reported.
  - Reset mid-operation drops all in-flight results silently.

## Timing
- Latency: a request granted at edge E produces `rsp_valid`=1 after WIDTH clock edges in which `add_en`=1 (E counts as the first). With no stalls, that is WIDTH cycles.
- Throughput: 1 issue per cycle whenever not stalled.
- Stall with a valid head: the head result, `rsp_id`, and every tag and adder stage hold until `rsp_ready`=1.
- A bubble at the head never stalls, because `rsp_valid`=0 keeps `add_en`=1.
- Retire and issue in the same cycle: both happen, and `inflight` is unchanged.
- Request held across a stall: `req_ready` stays 0 and `req_valid` with its operands must stay stable (requester obligation).

## Configuration
- `ADDER_ARB_RR_EN` defined: round-robin arbitration.
  - Pointer p (IDW bits, reset 0).
  - Search order p, p+1, …, wrapping modulo NREQ.
  - After a grant to k, p ← (k+1) mod NREQ. p only updates on a grant.
- Undefined: fixed priority, lowest index wins. No pointer register.

## Test plan
- Single request: reset, then one issue with requester 2, WIDTH=8, a=0x7F, b=0x01, cin=1 → 8 cycles later `rsp_valid`=1, `rsp_id`=2, `rsp_s`=0x81, `rsp_c`=0, `inflight` returns to 0 after retire.
- Overflow: a=0xFF, b=0xFF, cin=1 → `rsp_s`=0xFF, `rsp_c`=1.
- Back-to-back: all 4 requesters valid for 8 cycles with `RR_EN` → grants 0,1,2,3,0,1,2,3; responses follow in the same order one per cycle from cycle 8; `inflight` peaks at 8.
- Backpressure: stream 4 results, hold `rsp_ready`=0 for 5 cycles when the first result appears → `add_en`=0, `req_ready`=0, and `rsp_s`/`rsp_id` stable; on release, results resume in order with none lost or duplicated.
- Fixed priority (macro undefined): requesters 1 and 3 continuously valid → requester 1 granted every cycle, requester 3 never granted.
- Mid-flight reset: 5 results in flight, drive `rst`=0 for one edge → `rsp_valid`=0 and `inflight`=0 afterward; no stale result appears in the following WIDTH cycles.
